pad_bank_seq: RTL and testbench
===============================

Name: pad_bank_seq

Overview:
- Parametrised bank of NUM_PADS generic bidirectional IO pads, each built on a Xilinx IOBUF (LVCMOS33).
- Adds power-on release sequencing: every pad is held tri-stated after reset. Pads are then released in groups of STEP_PADS, with SETTLE_CYCLES between groups, to limit simultaneous-switching current on the SoC supply pads.
- Sits in the FPGA pad ring between SoC GPIO logic and package pins.
- Provides a registered output path and a synchronised input path per pad.

Parameters:
- NUM_PADS, 8, number of pads in the bank (1..32).
- STEP_PADS, 2, pads released per sequencing step (1..NUM_PADS).
- SETTLE_CYCLES, 16, wait cycles before each release step (>=1).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DRIVE, 8, IOBUF drive strength in mA.

Ports:
- CLK  input  1  bank clock.
- RST  input  1  synchronous, active-high reset.
- PAD  inout  NUM_PADS  package pins.
- seq_start  input  1  begin release sequence; only honoured in IDLE.
- seq_off  input  1  return all pads to tri-state from any state.
- sw_out_i  input  NUM_PADS  data to drive on each pad.
- sw_oe_i  input  NUM_PADS  per-pad output enable requested by SoC.
- sw_in_o  output  NUM_PADS  synchronised pad input value.
- pad_en_o  output  NUM_PADS  pads currently released by the sequencer.
- bank_ready_o  output  1  all pads released.

Behaviour:
- Reset: one clock and one reset only (CLK, RST); RST is synchronous and active-high.
- Values on reset: state=IDLE, pad_en_o=0, bank_ready_o=0, sw_in_o=0, step index=0, settle counter=0, all output/OE registers=0. Every IOBUF T=1 (hi-Z).
- State IDLE:
  - seq_start=1 -> SETTLE; counter loaded with SETTLE_CYCLES-1; index=0.
- State SETTLE:
  - Counter decrements each cycle.
  - Counter==0 -> STEP.
- State STEP (single cycle):
  - pad_en_o |= mask of bits [index, min(index+STEP_PADS, NUM_PADS)-1]; index += STEP_PADS.
  - If new index >= NUM_PADS -> READY.
  - Otherwise -> SETTLE with counter reloaded.
- State READY:
  - bank_ready_o=1 (registered, asserted on the cycle after the final STEP).
  - seq_start is ignored.
- seq_off:
  - In any non-IDLE state, goes to IDLE on the next edge and clears pad_en_o, bank_ready_o and the index in that same edge.
  - seq_off has priority over seq_start.
  - In IDLE, seq_off is a no-op.
- Sequence length:
  - NSTEPS = ceil(NUM_PADS/STEP_PADS).
  - bank_ready_o rises NSTEPS*(SETTLE_CYCLES+1)+1 edges after seq_start is sampled.
  - Defaults: 4*17+1 = 69 edges.
- Last group: if STEP_PADS does not divide NUM_PADS, the final step releases only the remaining pads; no bits above NUM_PADS-1 are ever set.
- Output path:
  - sw_out_i and sw_oe_i are registered once.
  - IOBUF I = registered out; IOBUF T = ~(registered oe & pad_en_o[i]).
  - Latency from sw_out_i/sw_oe_i to the pin is 1 cycle.
  - A pad not yet released stays hi-Z regardless of sw_oe_i.
- Input path:
  - IOBUF O passes through SYNC_STAGES flops, giving SYNC_STAGES cycles of latency.
  - sw_in_o[i] is forced to 0 while pad_en_o[i]=0, gated at the final stage.
- Mid-sequence RST: identical to the reset values above; pads return to hi-Z on that edge.
- Elaboration: parameter violations (STEP_PADS=0, SETTLE_CYCLES=0, NUM_PADS>32) are elaboration errors.

Decomposition:
- Package pad_bank_pkg:
  - state enum (IDLE, SETTLE, STEP, READY);
  - function num_steps(n, s) returning ceil(n/s);
  - function group_mask(idx, s, n).
- Sub-module pad_cell_io:
  - one IOBUF (LVCMOS33, DRIVE);
  - registered I/T;
  - SYNC_STAGES input synchroniser with enable gating.
  - Instantiated NUM_PADS times by generate.

Test Plan:
- Reset, then sw_oe_i=all 1s with no seq_start for 50 cycles -> all PAD hi-Z; pad_en_o=0; bank_ready_o=0; sw_in_o=0.
- Defaults; pulse seq_start -> pad_en_o goes 0x03, 0x0F, 0x3F, 0xFF at edges 17, 34, 51, 68; bank_ready_o=1 at edge 69.
- NUM_PADS=5, STEP_PADS=2, SETTLE_CYCLES=1 -> pad_en_o goes 0x03, 0x0F, 0x1F; bank_ready_o=1 after 7 edges.
- seq_off asserted while pad_en_o=0x0F -> next edge pad_en_o=0 and state IDLE; a seq_start held high in the same cycle is ignored.
- Bank in READY; set sw_out_i[3]=1, sw_oe_i[3]=1 -> PAD[3]=1 one cycle later. Drive the pin externally to 0 with oe=0 -> sw_in_o[3]=0 after 2 cycles.
- RST asserted at edge 40 of the sequence -> pad_en_o=0 and bank_ready_o=0 at that edge; a fresh seq_start repeats the full 69-edge timing.

Source files
------------

// File: rtl/pad_bank_pkg.sv
// Shared types and helpers for the sequenced pad bank: FSM states, step count
// and the per-step release mask.
package pad_bank_pkg;

    localparam int MAX_PADS = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STEP   = 2'd2,
        READY  = 2'd3
    } seq_state_t;

    function automatic int num_steps(input int n, input int s);
        return (n + s - 1) / s;
    endfunction

    // Bits [idx, min(idx+s, n)-1] set; nothing at or above n is ever set.
    function automatic logic [MAX_PADS-1:0] group_mask(input int idx, input int s, input int n);
        logic [MAX_PADS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PADS; i++) begin
            m[i] = (i >= idx) && (i < idx + s) && (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/pad_cell_io.sv
// One bidirectional LVCMOS33 pad: registered output/enable, gated release and
// a multi-stage input synchroniser. The tri-state assign maps onto an IOBUF.
module pad_cell_io
    import pad_bank_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DRIVE       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic dout,
    input  logic oe,
    (* IOSTANDARD = "LVCMOS33" *)
    inout  wire  pad,
    output logic din
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pad_cell_io: SYNC_STAGES must be >= 2");
    end
    if (DRIVE != 4 && DRIVE != 8 && DRIVE != 12 && DRIVE != 16) begin : g_bad_drive
        $error("pad_cell_io: DRIVE must be 4, 8, 12 or 16 mA for LVCMOS33");
    end

    logic                   out_r;
    logic                   oe_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   t;

    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r  <= 1'b0;
            oe_r   <= 1'b0;
            sync_r <= '0;
        end else begin
            out_r  <= dout;
            oe_r   <= oe;
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
        end
    end

    // An unreleased pad stays hi-Z whatever the SoC requests.
    assign t   = ~(oe_r & en);
    assign pad = t ? 1'bz : out_r;
    assign din = sync_r[SYNC_STAGES-1] & en;

endmodule

// File: rtl/pad_bank_seq.sv
// Pad bank with power-on release sequencing: pads leave hi-Z in groups of
// STEP_PADS, SETTLE_CYCLES apart, to limit simultaneous switching current.
module pad_bank_seq
    import pad_bank_pkg::*;
#(
    parameter int NUM_PADS      = 8,
    parameter int STEP_PADS     = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int DRIVE         = 8
) (
    input  logic                CLK,
    input  logic                RST,
    (* IOSTANDARD = "LVCMOS33" *)
    inout  wire  [NUM_PADS-1:0] PAD,
    input  logic                seq_start,
    input  logic                seq_off,
    input  logic [NUM_PADS-1:0] sw_out_i,
    input  logic [NUM_PADS-1:0] sw_oe_i,
    output logic [NUM_PADS-1:0] sw_in_o,
    output logic [NUM_PADS-1:0] pad_en_o,
    output logic                bank_ready_o
);

    if (NUM_PADS < 1 || NUM_PADS > MAX_PADS) begin : g_bad_num
        $error("pad_bank_seq: NUM_PADS must be 1..32");
    end
    if (STEP_PADS < 1 || STEP_PADS > NUM_PADS) begin : g_bad_step
        $error("pad_bank_seq: STEP_PADS must be 1..NUM_PADS");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("pad_bank_seq: SETTLE_CYCLES must be >= 1");
    end

    localparam int SAFE_STEP = (STEP_PADS > 0) ? STEP_PADS : 1;
    localparam int CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W     = $clog2(num_steps(NUM_PADS, SAFE_STEP) * SAFE_STEP + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] STEP_IDX = IDX_W'(SAFE_STEP);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_PADS);

    seq_state_t          state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [IDX_W-1:0]    idx, idx_nx, idx_step;
    logic [NUM_PADS-1:0] pad_en, pad_en_nx;
    logic                ready, ready_nx;
    logic                last_step;
    logic                abort;

    assign idx_step  = idx + STEP_IDX;
    assign last_step = (idx_step >= NUM_IDX);
    assign abort     = seq_off && (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            pad_en <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            pad_en <= pad_en_nx;
            ready  <= ready_nx;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (seq_start && !seq_off) state_nx = SETTLE;
                SETTLE:  if (cnt == '0) state_nx = STEP;
                STEP:    state_nx = last_step ? READY : SETTLE;
                default: state_nx = state;
            endcase
        end
    end

    // bank_ready is registered off the READY state, so it trails the final step by one edge.
    always_comb begin
        cnt_nx    = cnt;
        idx_nx    = idx;
        pad_en_nx = pad_en;
        ready_nx  = (state == READY) && !seq_off;
        if (abort) begin
            cnt_nx    = '0;
            idx_nx    = '0;
            pad_en_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seq_start && !seq_off) begin
                        cnt_nx = CNT_LOAD;
                        idx_nx = '0;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                end
                STEP: begin
                    pad_en_nx = pad_en | NUM_PADS'(group_mask(int'(idx), SAFE_STEP, NUM_PADS));
                    idx_nx    = idx_step;
                    if (!last_step) cnt_nx = CNT_LOAD;
                end
                default: ;
            endcase
        end
    end

    assign pad_en_o     = pad_en;
    assign bank_ready_o = ready;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        pad_cell_io #(
            .SYNC_STAGES(SYNC_STAGES),
            .DRIVE      (DRIVE)
        ) u_cell (
            .clk (CLK),
            .rst (RST),
            .en  (pad_en[g]),
            .dout(sw_out_i[g]),
            .oe  (sw_oe_i[g]),
            .pad (PAD[g]),
            .din (sw_in_o[g])
        );
    end

endmodule

// File: tb/tb_pad_bank_seq.sv
// Self-checking bench: two pad banks (default and 5/2/1) against a timing
// model of the release schedule, plus pin and synchroniser behaviour.
module tb_pad_bank_seq;

    localparam int NP [2] = '{8, 5};
    localparam int PS [2] = '{2, 2};
    localparam int SC [2] = '{16, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       seq_start;
    logic       seq_off;
    logic [7:0] sw_out;
    logic [7:0] sw_oe;

    wire  [7:0] pad0;
    wire  [4:0] pad1;
    logic [7:0] sw_in0, pad_en0;
    logic [4:0] sw_in1, pad_en1;
    logic       rdy0, rdy1;

    logic [7:0] ext_en0, ext_val0;
    logic [4:0] ext_en1, ext_val1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_ext0
        assign pad0[i] = ext_en0[i] ? ext_val0[i] : 1'bz;
    end
    for (genvar i = 0; i < 5; i++) begin : g_ext1
        assign pad1[i] = ext_en1[i] ? ext_val1[i] : 1'bz;
    end

    pad_bank_seq #(
        .NUM_PADS(8), .STEP_PADS(2), .SETTLE_CYCLES(16), .SYNC_STAGES(2), .DRIVE(8)
    ) dut0 (
        .CLK(clk), .RST(rst), .PAD(pad0), .seq_start(seq_start), .seq_off(seq_off),
        .sw_out_i(sw_out), .sw_oe_i(sw_oe), .sw_in_o(sw_in0),
        .pad_en_o(pad_en0), .bank_ready_o(rdy0)
    );

    pad_bank_seq #(
        .NUM_PADS(5), .STEP_PADS(2), .SETTLE_CYCLES(1), .SYNC_STAGES(2), .DRIVE(8)
    ) dut1 (
        .CLK(clk), .RST(rst), .PAD(pad1), .seq_start(seq_start), .seq_off(seq_off),
        .sw_out_i(sw_out[4:0]), .sw_oe_i(sw_oe[4:0]), .sw_in_o(sw_in1),
        .pad_en_o(pad_en1), .bank_ready_o(rdy1)
    );

    // Reference model: elapsed edges since an honoured start, plus pin history.
    bit          running [2] = '{0, 0};
    int          t       [2] = '{0, 0};
    logic [31:0] out_r   [2] = '{0, 0};
    logic [31:0] oe_r    [2] = '{0, 0};
    logic [31:0] h_new   [2] = '{0, 0};
    logic [31:0] h_old   [2] = '{0, 0};
    logic [31:0] ext_v   [2] = '{0, 0};
    bit          ext_random = 1'b1;
    logic        ext_const  = 1'b0;

    function automatic logic [31:0] low_mask(input int k);
        if (k >= 32) return '1;
        return (32'd1 << k) - 32'd1;
    endfunction

    function automatic logic [31:0] exp_en(input int d);
        int k;
        if (!running[d]) return '0;
        k = PS[d] * (t[d] / (SC[d] + 1));
        if (k > NP[d]) k = NP[d];
        return low_mask(k);
    endfunction

    function automatic logic [31:0] exp_rdy(input int d);
        int nsteps;
        nsteps = (NP[d] + PS[d] - 1) / PS[d];
        return (running[d] && t[d] >= nsteps * (SC[d] + 1) + 1) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_drive(input int d);
        return oe_r[d] & exp_en(d);
    endfunction

    function automatic logic [31:0] exp_pin(input int d);
        logic [31:0] drv;
        drv = exp_drive(d);
        return (drv & out_r[d]) | (~drv & ext_v[d] & low_mask(NP[d]));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int d, input logic [31:0] pin);
        if (rst) begin
            running[d] = 1'b0;
            t[d]       = 0;
            out_r[d]   = '0;
            oe_r[d]    = '0;
            h_new[d]   = '0;
            h_old[d]   = '0;
        end else begin
            h_old[d] = h_new[d];
            h_new[d] = pin;
            out_r[d] = {24'b0, sw_out} & low_mask(NP[d]);
            oe_r[d]  = {24'b0, sw_oe} & low_mask(NP[d]);
            if (running[d]) begin
                if (seq_off) running[d] = 1'b0;
                else if (t[d] < 100000) t[d]++;
            end else if (seq_start && !seq_off) begin
                running[d] = 1'b1;
                t[d]       = 0;
            end
        end
    endtask

    task automatic cycle();
        logic [31:0] pin_b [2];
        logic [31:0] drv0, drv1;
        for (int d = 0; d < 2; d++) pin_b[d] = exp_pin(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d, pin_b[d]);
        #1;
        for (int d = 0; d < 2; d++) ext_v[d] = ext_random ? $urandom : {32{ext_const}};
        drv0     = exp_drive(0);
        drv1     = exp_drive(1);
        ext_val0 = ext_v[0][7:0];
        ext_val1 = ext_v[1][4:0];
        ext_en0  = ~drv0[7:0];
        ext_en1  = ~drv1[4:0];
        #1;
        check("en0",  {24'b0, pad_en0}, exp_en(0));
        check("rdy0", {31'b0, rdy0},    exp_rdy(0));
        check("in0",  {24'b0, sw_in0},  h_old[0] & exp_en(0));
        check("pad0", {24'b0, pad0},    exp_pin(0));
        check("en1",  {27'b0, pad_en1}, exp_en(1));
        check("rdy1", {31'b0, rdy1},    exp_rdy(1));
        check("in1",  {27'b0, sw_in1},  h_old[1] & exp_en(1));
        check("pad1", {27'b0, pad1},    exp_pin(1));
    endtask

    initial begin
        rst       = 1'b1;
        seq_start = 1'b0;
        seq_off   = 1'b0;
        sw_out    = '0;
        sw_oe     = '0;
        ext_v[0]  = $urandom;
        ext_v[1]  = $urandom;
        ext_val0  = ext_v[0][7:0];
        ext_val1  = ext_v[1][4:0];
        ext_en0   = '1;
        ext_en1   = '1;

        repeat (3) cycle();
        check("rst_en0",  {24'b0, pad_en0}, 32'h0);
        check("rst_rdy0", {31'b0, rdy0},    32'h0);
        check("rst_in0",  {24'b0, sw_in0},  32'h0);
        rst = 1'b0;

        // No start: everything stays hi-Z even with all enables requested.
        sw_out = '1;
        sw_oe  = '1;
        repeat (50) cycle();
        check("idle_en0",  {24'b0, pad_en0}, 32'h0);
        check("idle_rdy0", {31'b0, rdy0},    32'h0);
        check("idle_in0",  {24'b0, sw_in0},  32'h0);

        // Full release schedule on both banks from one start pulse.
        seq_start = 1'b1;
        cycle();
        seq_start = 1'b0;
        for (int e = 1; e <= 70; e++) begin
            cycle();
            case (e)
                2:  check("b1_e2",  {27'b0, pad_en1}, 32'h03);
                4:  check("b1_e4",  {27'b0, pad_en1}, 32'h0F);
                6:  begin
                        check("b1_e6",  {27'b0, pad_en1}, 32'h1F);
                        check("b1_r6",  {31'b0, rdy1},    32'h0);
                    end
                7:  check("b1_r7",  {31'b0, rdy1},    32'h1);
                16: check("b0_e16", {24'b0, pad_en0}, 32'h00);
                17: check("b0_e17", {24'b0, pad_en0}, 32'h03);
                34: check("b0_e34", {24'b0, pad_en0}, 32'h0F);
                51: check("b0_e51", {24'b0, pad_en0}, 32'h3F);
                68: begin
                        check("b0_e68", {24'b0, pad_en0}, 32'hFF);
                        check("b0_r68", {31'b0, rdy0},    32'h0);
                    end
                69: check("b0_r69", {31'b0, rdy0},    32'h1);
                default: ;
            endcase
        end

        // Output on pad 3, then release it and let the outside pull it low.
        sw_out     = 8'h08;
        sw_oe      = 8'h08;
        ext_random = 1'b0;
        ext_const  = 1'b0;
        cycle();
        check("pad3_hi", {31'b0, pad0[3]}, 32'h1);
        repeat (3) cycle();
        check("in3_hi", {31'b0, sw_in0[3]}, 32'h1);
        sw_oe = 8'h00;
        cycle();
        check("pad3_lo", {31'b0, pad0[3]},   32'h0);
        check("in3_a",   {31'b0, sw_in0[3]}, 32'h1);
        cycle();
        check("in3_b",   {31'b0, sw_in0[3]}, 32'h1);
        cycle();
        check("in3_c",   {31'b0, sw_in0[3]}, 32'h0);
        ext_random = 1'b1;

        // seq_off mid-sequence beats a simultaneous seq_start.
        seq_off = 1'b1;
        cycle();
        seq_off   = 1'b0;
        seq_start = 1'b1;
        cycle();
        seq_start = 1'b0;
        repeat (34) cycle();
        check("off_pre", {24'b0, pad_en0}, 32'h0F);
        seq_off   = 1'b1;
        seq_start = 1'b1;
        cycle();
        check("off_en0", {24'b0, pad_en0}, 32'h0);
        seq_off   = 1'b0;
        seq_start = 1'b0;
        repeat (20) cycle();
        check("off_stay", {24'b0, pad_en0}, 32'h0);

        // Reset on edge 40, then a fresh full-length sequence.
        seq_start = 1'b1;
        cycle();
        seq_start = 1'b0;
        repeat (39) cycle();
        rst = 1'b1;
        cycle();
        check("r40_en0",  {24'b0, pad_en0}, 32'h0);
        check("r40_rdy0", {31'b0, rdy0},    32'h0);
        rst       = 1'b0;
        seq_start = 1'b1;
        cycle();
        seq_start = 1'b0;
        repeat (68) cycle();
        check("r40_r68", {31'b0, rdy0}, 32'h0);
        cycle();
        check("r40_r69", {31'b0, rdy0}, 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            seq_start = ($urandom_range(0, 19) == 0);
            seq_off   = ($urandom_range(0, 149) == 0);
            sw_out    = 8'($urandom);
            sw_oe     = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
